// File: rtl/sd_emmc_raid0_pkg.sv
// Shared types and constants for the eMMC RAID0 stripe controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package sd_emmc_raid0_pkg;

    // Default width of the host block count
    localparam int BLK_CNT_W = 16;

    // Command indices issued on the shared command engine
    localparam logic [5:0] CMD18 = 6'd18;  // READ_MULTIPLE_BLOCK
    localparam logic [5:0] CMD23 = 6'd23;  // SET_BLOCK_COUNT
    localparam logic [5:0] CMD25 = 6'd25;  // WRITE_MULTIPLE_BLOCK

    // Request sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETCNT,
        ST_XFER,
        ST_DATA,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/sd_emmc_raid0_addr_split.sv
// Splits a host LBA range into per-device start LBAs and block counts (1-block stripes).
// Latency: combinational.
// Backpressure: none.
module sd_emmc_raid0_addr_split
    import sd_emmc_raid0_pkg::*;
#(
    parameter int CNT_W = BLK_CNT_W
) (
    input  logic [31:0]      lba,
    input  logic [CNT_W-1:0] n,
    output logic [31:0]      dev0_lba,
    output logic [31:0]      dev1_lba,
    output logic [CNT_W-1:0] dev0_cnt,
    output logic [CNT_W-1:0] dev1_cnt
);

    logic [32:0]      lba_up;
    logic [CNT_W-1:0] half_ceil;
    logic [CNT_W-1:0] half_floor;

    // Even LBAs live on dev0, odd on dev1; the first even LBA at or after lba needs 33 bits
    always_comb begin
        lba_up     = {1'b0, lba} + 33'd1;
        dev0_lba   = lba_up[32:1];
        dev1_lba   = {1'b0, lba[31:1]};
        half_floor = n >> 1;
        half_ceil  = half_floor + {{(CNT_W-1){1'b0}}, n[0]};
        // The device owning the first block gets the extra block of an odd count
        dev0_cnt   = lba[0] ? half_floor : half_ceil;
        dev1_cnt   = lba[0] ? half_ceil  : half_floor;
    end

endmodule

// File: rtl/sd_emmc_raid0_stripe_ctrl.sv
// Sequences one host multi-block request as CMD23+CMD18/25 per device, then steers data blocks.
// Latency: cmd_start_o one cycle after SETCNT/XFER entry; done_o one cycle after the last blk_done_i.
// Backpressure: req_ready_o low outside IDLE; commands wait indefinitely-bounded by the watchdog.
module sd_emmc_raid0_stripe_ctrl
    import sd_emmc_raid0_pkg::*;
#(
    parameter int CMD_TIMEOUT = 4096,
    parameter int BLK_CNT_W   = sd_emmc_raid0_pkg::BLK_CNT_W
) (
    input  logic                 sd_clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [31:0]          req_lba_i,
    input  logic [BLK_CNT_W-1:0] req_blk_cnt_i,
    output logic                 cmd_start_o,
    output logic                 cmd_dev_o,
    output logic [5:0]           cmd_index_o,
    output logic [31:0]          cmd_arg_o,
    input  logic                 cmd_done_i,
    input  logic                 cmd_err_i,
    input  logic                 blk_done_i,
    output logic                 dev_sel_o,
    output logic                 xfer_active_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int WD_W = $clog2(CMD_TIMEOUT + 1);

    state_t               state;
    logic                 issued;     // command for the current state already launched
    logic                 first_dev;  // device owning the first host block
    logic                 wr_lat;
    logic [BLK_CNT_W-1:0] rem;
    logic [BLK_CNT_W-1:0] cnt0, cnt1;
    logic [31:0]          lba0, lba1;
    logic [WD_W-1:0]      wdog;
    logic [WD_W-1:0]      wdog_nxt;

    logic [31:0]          split_lba0, split_lba1;
    logic [BLK_CNT_W-1:0] split_cnt0, split_cnt1;
    logic [BLK_CNT_W-1:0] cur_cnt;
    logic [31:0]          cur_lba;

    sd_emmc_raid0_addr_split #(
        .CNT_W (BLK_CNT_W)
    ) u_split (
        .lba      (req_lba_i),
        .n        (req_blk_cnt_i),
        .dev0_lba (split_lba0),
        .dev1_lba (split_lba1),
        .dev0_cnt (split_cnt0),
        .dev1_cnt (split_cnt1)
    );

    // Per-device operands for the command being issued
    always_comb begin
        cur_cnt  = cmd_dev_o ? cnt1 : cnt0;
        cur_lba  = cmd_dev_o ? lba1 : lba0;
        wdog_nxt = wdog + {{(WD_W-1){1'b0}}, 1'b1};
    end

    // Request FSM with watchdog, block counter and registered outputs
    always_ff @(posedge sd_clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            issued        <= 1'b0;
            first_dev     <= 1'b0;
            wr_lat        <= 1'b0;
            rem           <= '0;
            cnt0          <= '0;
            cnt1          <= '0;
            lba0          <= '0;
            lba1          <= '0;
            wdog          <= '0;
            req_ready_o   <= 1'b1;
            cmd_start_o   <= 1'b0;
            cmd_dev_o     <= 1'b0;
            cmd_index_o   <= '0;
            cmd_arg_o     <= '0;
            dev_sel_o     <= 1'b0;
            xfer_active_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            cmd_start_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        first_dev <= req_lba_i[0];
                        wr_lat    <= req_write_i;
                        rem       <= req_blk_cnt_i;
                        cnt0      <= split_cnt0;
                        cnt1      <= split_cnt1;
                        lba0      <= split_lba0;
                        lba1      <= split_lba1;
                        if (req_blk_cnt_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            req_ready_o <= 1'b0;
                            issued      <= 1'b0;
                            // Skip dev0 entirely when it owns no block of this request
                            cmd_dev_o   <= (split_cnt0 == '0);
                            state       <= ST_SETCNT;
                        end
                    end
                end
                ST_SETCNT, ST_XFER: begin
                    if (!issued) begin
                        cmd_start_o <= 1'b1;
                        issued      <= 1'b1;
                        wdog        <= '0;
                        if (state == ST_SETCNT) begin
                            cmd_index_o <= CMD23;
                            cmd_arg_o   <= {{(32-BLK_CNT_W){1'b0}}, cur_cnt};
                        end else begin
                            cmd_index_o <= wr_lat ? CMD25 : CMD18;
                            cmd_arg_o   <= cur_lba;
                        end
                    end else if (cmd_err_i || (wdog_nxt >= WD_W'(CMD_TIMEOUT))) begin
                        // Error has priority over a coincident completion
                        err_o <= 1'b1;
                        state <= ST_ERROR;
                    end else if (cmd_done_i) begin
                        issued <= 1'b0;
                        if (state == ST_SETCNT) begin
                            state <= ST_XFER;
                        end else if (!cmd_dev_o && (cnt1 != '0)) begin
                            cmd_dev_o <= 1'b1;
                            state     <= ST_SETCNT;
                        end else begin
                            dev_sel_o     <= first_dev;
                            xfer_active_o <= 1'b1;
                            state         <= ST_DATA;
                        end
                    end else begin
                        wdog <= wdog_nxt;
                    end
                end
                ST_DATA: begin
                    if (blk_done_i) begin
                        if (rem == {{(BLK_CNT_W-1){1'b0}}, 1'b1}) begin
                            // Last block: finish without toggling the steering
                            rem           <= '0;
                            done_o        <= 1'b1;
                            xfer_active_o <= 1'b0;
                            req_ready_o   <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            rem       <= rem - {{(BLK_CNT_W-1){1'b0}}, 1'b1};
                            dev_sel_o <= ~dev_sel_o;
                        end
                    end
                end
                ST_ERROR: begin
                    xfer_active_o <= 1'b0;
                    req_ready_o   <= 1'b1;
                    issued        <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: begin
                    req_ready_o <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
